// File: rtl/seq_divider_nbit_if.sv
// Start/done bus of the sequential restoring divider (2N-bit dividend, N-bit divisor).
// Carries the request operands, the result outputs and a state view for debug.
interface seq_divider_nbit_if #(
  parameter int N = 6
);
  // start is honoured only on an edge where busy is low; the operands are
  // captured on that edge. done marks the cycle in which quotient,
  // remainder, dbz and ovf are the result of that request, and those
  // outputs then hold until the next accepted start.
  logic           start;
  logic [2*N-1:0] dividend;
  logic [N-1:0]   divisor;
  logic           busy;
  logic           done;
  logic [N-1:0]   quotient;
  logic [N-1:0]   remainder;
  logic           dbz;
  logic           ovf;
  logic [1:0]     dbg_state;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, dbz, ovf, dbg_state
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, dbz, ovf, dbg_state
  );
endinterface

// File: rtl/seq_divider_nbit.sv
// Sequential restoring divider: 2N/N unsigned, one quotient bit per clock.
// Optional macro SEQ_DIVIDER_DONE_HOLD_EN turns done into a level held until the next accepted start.
module seq_divider_nbit #(
  parameter int N = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  seq_divider_nbit_if.slave bus
);
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  logic [N-1:0]  r_reg;
  logic [N-1:0]  q_reg;
  logic [N-1:0]  d_reg;
  logic [CW-1:0] cnt;
  logic          pend_dbz;
  logic          pend_ovf;

  logic          busy_r;
  logic          done_r;
  logic [N-1:0]  quot_r;
  logic [N-1:0]  rem_r;
  logic          dbz_r;
  logic          ovf_r;

  logic [N:0]    t;
  logic          ge;
  logic [N-1:0]  r_nxt;
  logic [N-1:0]  q_nxt;
  logic          in_dbz;
  logic          in_ovf;

  // The partial remainder stays below D, so its top bit is always zero and
  // only the low N bits are stored; t[N] still takes part in the compare.
  always_comb begin
    t      = {r_reg, q_reg[N-1]};
    ge     = (t >= {1'b0, d_reg});
    r_nxt  = ge ? (t[N-1:0] - d_reg) : t[N-1:0];
    q_nxt  = {q_reg[N-2:0], ge};
    in_dbz = (bus.divisor == '0);
    in_ovf = !in_dbz && (bus.dividend[2*N-1:N] >= bus.divisor);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      r_reg    <= '0;
      q_reg    <= '0;
      d_reg    <= '0;
      cnt      <= '0;
      pend_dbz <= 1'b0;
      pend_ovf <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      quot_r   <= '0;
      rem_r    <= '0;
      dbz_r    <= 1'b0;
      ovf_r    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            busy_r   <= 1'b1;
            dbz_r    <= 1'b0;
            ovf_r    <= 1'b0;
`ifdef SEQ_DIVIDER_DONE_HOLD_EN
            done_r   <= 1'b0;
`endif
            r_reg    <= bus.dividend[2*N-1:N];
            q_reg    <= bus.dividend[N-1:0];
            d_reg    <= bus.divisor;
            pend_dbz <= in_dbz;
            pend_ovf <= in_ovf;
            cnt      <= (in_dbz || in_ovf) ? CW'(1) : CW'(N);
            state    <= CALC;
          end
        end
        CALC: begin
          // Error results skip the iterations but keep one edge of latency.
          if (pend_dbz || pend_ovf) begin
            quot_r <= '1;
            rem_r  <= pend_dbz ? q_reg : '0;
            dbz_r  <= pend_dbz;
            ovf_r  <= pend_ovf;
            done_r <= 1'b1;
            cnt    <= '0;
            state  <= DONE;
          end else begin
            r_reg <= r_nxt;
            q_reg <= q_nxt;
            cnt   <= cnt - 1'b1;
            if (cnt == CW'(1)) begin
              quot_r <= q_nxt;
              rem_r  <= r_nxt;
              done_r <= 1'b1;
              state  <= DONE;
            end
          end
        end
        DONE: begin
          busy_r <= 1'b0;
`ifndef SEQ_DIVIDER_DONE_HOLD_EN
          done_r <= 1'b0;
`endif
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.quotient  = quot_r;
  assign bus.remainder = rem_r;
  assign bus.dbz       = dbz_r;
  assign bus.ovf       = ovf_r;
  assign bus.dbg_state = state;
endmodule
